div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//  - Multi-cycle companion to the single-cycle integer ALU in execute_stage.
//  - Execute issues a request over a valid/ready handshake, stalls, and takes the result on a second handshake.
//  - One operation in flight; results follow RISC-V M-spec corner-case rules.
// PARAMETERS
//  XLEN   32  operand/result width, taken from riscv_core_pkg
//  TAG_W  5   width of opaque destination tag (rd) carried request->response
// PORTS
//  clk_i         in   1      core clock
//  rst_ni        in   1      async active-low reset
//  req_valid_i   in   1      request valid
//  req_ready_o   out  1      unit can accept (IDLE only)
//  div_op_i      in   div_op_e  DIV/DIVU/REM/REMU
//  operand_a_i   in   XLEN   dividend (rs1)
//  operand_b_i   in   XLEN   divisor (rs2)
//  req_tag_i     in   TAG_W  destination tag
//  kill_i        in   1      pipeline flush; abort any operation
//  rsp_valid_o   out  1      result valid
//  rsp_ready_i   in   1      consumer accepts result
//  rsp_result_o  out  XLEN   quotient or remainder
//  rsp_tag_o     out  TAG_W  tag of completed request
//  busy_o        out  1      state != IDLE
// BEHAVIOUR
//  - Interface: one clock, clk_i; reset is asynchronous and active-low, rst_ni.
//  - Reset: state=IDLE, counter=0, rsp_valid_o=0, rsp_result_o=0, rsp_tag_o=0, busy_o=0, req_ready_o=1.
//  - FSM: IDLE -> CALC -> DONE -> IDLE.
//  - IDLE:
//    - req_ready_o=1.
//    - On req_valid_i && !kill_i: latch op and tag.
//    - Latch |a| and |b|; operands are treated as signed only for DIV/REM.
//    - Record quotient sign = sa^sb and remainder sign = sa.
//    - Load count = XLEN-1; go to CALC.
//  - CALC, one iteration per cycle:
//    - Shift {rem,quo} left 1.
//    - trial = rem - |b| (XLEN+1 bits).
//    - If trial is non-negative: rem = trial, quo[0] = 1.
//    - When count==0, go to DONE.
//  - Latency: request accepted at edge t; rsp_valid_o is high from edge t+XLEN.
//  - DONE:
//    - rsp_valid_o=1; result and tag stay stable until rsp_ready_i.
//    - On rsp_valid_o && rsp_ready_i, go to IDLE.
//    - No accept in the same cycle, so throughput is 1 op per XLEN+2 cycles minimum.
//  - Result:
//    - Quotient/remainder are negated per the latched signs, then selected by op.
//    - Divide by zero: quotient = all ones, remainder = a (original, unsigned-view bits).
//    - Signed overflow (a = 0x8000_0000, b = -1, DIV/REM): quotient = 0x8000_0000, remainder = 0.
//    - Corner cases are forced at DONE entry and override the datapath value.
//  - kill_i: from any state, go to IDLE at the next edge with rsp_valid_o=0; no response is ever produced.
//  - kill_i has priority over a same-cycle accept and over a same-cycle response handshake.
//  - Reset mid-operation: immediate return to reset values; no response.
// CONFIGURATION
//  - Macro DIV_UNIT_FAST_SPECIAL_EN.
//  - Defined:
//    - Divide-by-zero and signed-overflow are detected in IDLE at accept.
//    - FSM goes IDLE -> DONE directly; rsp_valid_o is high from edge t+1.
//    - Dividend-zero requests also complete at t+1 with result 0.
//  - Undefined: every request takes the full XLEN-iteration path; special results are still forced at DONE entry.
//  - Response latency is the only difference.
// STRUCTURE
//  - riscv_core_pkg gains:
//    - div_op_e: DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU.
//    - div_state_e: IDLE, CALC, DONE.
//    - localparam DIV_CNT_W = $clog2(XLEN).
//  - Sub-module div_step (combinational): one restoring iteration. Inputs rem, quo, divisor; outputs next rem and quo.
//  - div_unit owns the FSM, counter, sign handling and handshakes.
// TESTING
//  - DIVU 100/7 tag 3: rsp_result_o=14, rsp_tag_o=3; rsp_valid_o exactly XLEN cycles after accept.
//  - REM -7/2: 0xFFFF_FFFF. DIV -7/2: 0xFFFF_FFFD. REMU 0xFFFF_FFF9/2: 1.
//  - DIV 5/0: 0xFFFF_FFFF. REM 5/0: 5. With the macro, the response arrives at t+1.
//  - DIV 0x8000_0000/-1: 0x8000_0000. REM of the same: 0.
//  - Hold rsp_ready_i=0 for 5 cycles in DONE: result and tag stable, req_ready_o=0. Release: IDLE next cycle.
//  - Assert kill_i at CALC iteration 10: no rsp_valid_o, req_ready_o=1 next cycle.
//  - Deassert rst_ni mid-CALC: outputs at reset values; no response.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// ----------------------------------------------------------------------------
// riscv_core_pkg
// Shared core-wide types and constants used by the iterative divider:
//   XLEN        - integer register width
//   DIV_CNT_W   - width of the divider iteration counter
//   div_op_e    - DIV / DIVU / REM / REMU operation select
//   div_state_e - divider FSM states
// Helpers:
//   cond_neg    - two's-complement negate when a flag is set
//   div_result  - final result selection including RISC-V corner cases
// ----------------------------------------------------------------------------
package riscv_core_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_CNT_W = $clog2(XLEN);

    localparam logic [XLEN-1:0] XLEN_ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] XLEN_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] XLEN_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        logic [XLEN-1:0] res;
        if (neg) begin
            res = (~v) + XLEN'(1);
        end else begin
            res = v;
        end
        return res;
    endfunction

    // Corner cases take precedence over the magnitude datapath; the remainder
    // of a divide-by-zero is the untouched dividend bit pattern.
    function automatic logic [XLEN-1:0] div_result(
        input div_op_e         op,
        input logic [XLEN-1:0] quo_mag,
        input logic [XLEN-1:0] rem_mag,
        input logic            neg_quo,
        input logic            neg_rem,
        input logic            div_zero,
        input logic            sgn_ovf,
        input logic [XLEN-1:0] dividend
    );
        logic [XLEN-1:0] quo_f;
        logic [XLEN-1:0] rem_f;
        logic [XLEN-1:0] res;
        if (div_zero) begin
            quo_f = XLEN_ONES;
            rem_f = dividend;
        end else if (sgn_ovf) begin
            quo_f = XLEN_MIN;
            rem_f = XLEN_ZERO;
        end else begin
            quo_f = cond_neg(quo_mag, neg_quo);
            rem_f = cond_neg(rem_mag, neg_rem);
        end
        case (op)
            DIV_OP_DIV, DIV_OP_DIVU: res = quo_f;
            DIV_OP_REM, DIV_OP_REMU: res = rem_f;
            default:                 res = quo_f;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring division iteration on magnitudes.
// Ports:
//   rem, quo, divisor      - current partial remainder, quotient/dividend
//                            shift register and divisor magnitude
//   rem_next, quo_next     - state after one shift-and-trial-subtract step
// ----------------------------------------------------------------------------
module div_step
    import riscv_core_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    // The shifted remainder can need XLEN+1 bits before the subtraction.
    logic [XLEN:0] shifted_s;
    logic [XLEN:0] trial_s;

    assign shifted_s = {rem, quo[XLEN-1]};
    assign trial_s   = shifted_s - {1'b0, divisor};

    // Restore (keep shifted value) when the trial subtraction went negative.
    always_comb begin
        rem_next = shifted_s[XLEN-1:0];
        quo_next = {quo[XLEN-2:0], 1'b0};
        if (!trial_s[XLEN]) begin
            rem_next = trial_s[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted_s[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One operation in flight; request and response use valid/ready handshakes.
// Ports:
//   clk_i, rst_ni                 - clock, async active-low reset
//   req_valid_i / req_ready_o     - request handshake (ready only in IDLE)
//   div_op_i, operand_a_i,
//   operand_b_i, req_tag_i        - operation, dividend, divisor, dest tag
//   kill_i                        - flush; aborts any operation, no response
//   rsp_valid_o / rsp_ready_i     - response handshake
//   rsp_result_o, rsp_tag_o       - quotient or remainder, tag
//   busy_o                        - unit not IDLE
// Build option DIV_UNIT_FAST_SPECIAL_EN: divide-by-zero, signed overflow and
// zero dividend complete one cycle after accept instead of XLEN cycles.
// ----------------------------------------------------------------------------
module div_unit
    import riscv_core_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  div_op_e          div_op_i,
    input  logic [XLEN-1:0]  operand_a_i,
    input  logic [XLEN-1:0]  operand_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic             kill_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [XLEN-1:0]  rsp_result_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             busy_o
);

    div_state_e             state_r, state_s;
    logic [DIV_CNT_W-1:0]   cnt_r;
    logic [XLEN-1:0]        rem_r, quo_r, divisor_r, dividend_r;
    div_op_e                op_r;
    logic                   neg_quo_r, neg_rem_r, div_zero_r, sgn_ovf_r;
    logic                   rsp_valid_r;
    logic [XLEN-1:0]        result_r;
    logic [TAG_W-1:0]       tag_r;

    logic                   accept_s, signed_op_s, sa_s, sb_s;
    logic                   in_div_zero_s, in_sgn_ovf_s, fast_s;
    logic [XLEN-1:0]        step_rem_s, step_quo_s;

    assign accept_s      = (state_r == IDLE) && req_valid_i && !kill_i;
    assign signed_op_s   = (div_op_i == DIV_OP_DIV) || (div_op_i == DIV_OP_REM);
    assign sa_s          = signed_op_s && operand_a_i[XLEN-1];
    assign sb_s          = signed_op_s && operand_b_i[XLEN-1];
    assign in_div_zero_s = (operand_b_i == XLEN_ZERO);
    assign in_sgn_ovf_s  = signed_op_s && (operand_a_i == XLEN_MIN) && (operand_b_i == XLEN_ONES);

`ifdef DIV_UNIT_FAST_SPECIAL_EN
    logic in_a_zero_s;
    assign in_a_zero_s = (operand_a_i == XLEN_ZERO);
    assign fast_s      = in_div_zero_s || in_sgn_ovf_s || in_a_zero_s;
`else
    assign fast_s      = 1'b0;
`endif

    div_step u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (divisor_r),
        .rem_next (step_rem_s),
        .quo_next (step_quo_s)
    );

    // Next-state logic; kill overrides accept and response handshakes.
    always_comb begin
        state_s = state_r;
        if (kill_i) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_s = fast_s ? DONE : CALC;
                    end else begin
                        state_s = IDLE;
                    end
                end
                CALC: begin
                    if (cnt_r == DIV_CNT_W'(0)) begin
                        state_s = DONE;
                    end else begin
                        state_s = CALC;
                    end
                end
                DONE: begin
                    if (rsp_valid_r && rsp_ready_i) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DONE;
                    end
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, iteration datapath and registered response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r       <= DIV_CNT_W'(0);
            rem_r       <= XLEN_ZERO;
            quo_r       <= XLEN_ZERO;
            divisor_r   <= XLEN_ZERO;
            dividend_r  <= XLEN_ZERO;
            op_r        <= DIV_OP_DIV;
            neg_quo_r   <= 1'b0;
            neg_rem_r   <= 1'b0;
            div_zero_r  <= 1'b0;
            sgn_ovf_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            result_r    <= XLEN_ZERO;
            tag_r       <= {TAG_W{1'b0}};
        end else if (kill_i) begin
            rsp_valid_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r      <= DIV_CNT_W'(XLEN-1);
            rem_r      <= XLEN_ZERO;
            quo_r      <= cond_neg(operand_a_i, sa_s);
            divisor_r  <= cond_neg(operand_b_i, sb_s);
            dividend_r <= operand_a_i;
            op_r       <= div_op_i;
            neg_quo_r  <= sa_s ^ sb_s;
            neg_rem_r  <= sa_s;
            div_zero_r <= in_div_zero_s;
            sgn_ovf_r  <= in_sgn_ovf_s;
            tag_r      <= req_tag_i;
            if (fast_s) begin
                // Zero magnitudes give a zero result for a zero dividend.
                rsp_valid_r <= 1'b1;
                result_r    <= div_result(div_op_i, XLEN_ZERO, XLEN_ZERO, 1'b0, 1'b0,
                                          in_div_zero_s, in_sgn_ovf_s, operand_a_i);
            end else begin
                rsp_valid_r <= 1'b0;
            end
        end else if (state_r == CALC) begin
            rem_r <= step_rem_s;
            quo_r <= step_quo_s;
            if (cnt_r == DIV_CNT_W'(0)) begin
                rsp_valid_r <= 1'b1;
                result_r    <= div_result(op_r, step_quo_s, step_rem_s, neg_quo_r, neg_rem_r,
                                          div_zero_r, sgn_ovf_r, dividend_r);
            end else begin
                cnt_r <= cnt_r - DIV_CNT_W'(1);
            end
        end else if ((state_r == DONE) && rsp_valid_r && rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    assign req_ready_o  = (state_r == IDLE);
    assign busy_o       = (state_r != IDLE);
    assign rsp_valid_o  = rsp_valid_r;
    assign rsp_result_o = result_r;
    assign rsp_tag_o    = tag_r;

endmodule

// File: tb/tb_div_unit.sv
// ----------------------------------------------------------------------------
// tb_div_unit
// Directed self-checking bench for div_unit. Expected values are computed by
// hand from the RISC-V M division rules.
// ----------------------------------------------------------------------------
module tb_div_unit;
    import riscv_core_pkg::*;

`ifdef DIV_UNIT_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 32;
`endif
    localparam int NORM_LAT = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    div_op_e     div_op;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  req_tag;
    logic        kill;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_tag;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    div_unit #(.TAG_W(5)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .div_op_i     (div_op),
        .operand_a_i  (operand_a),
        .operand_b_i  (operand_b),
        .req_tag_i    (req_tag),
        .kill_i       (kill),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_tag_o    (rsp_tag),
        .busy_o       (busy)
    );

    // Issue one request, wait for the response (bounded), then retire it.
    // lat = number of rising edges after the accept edge until rsp_valid; -1 on timeout.
    task automatic issue(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output logic [31:0] res,
                         output logic [4:0] tg, output int lat);
        @(negedge clk);
        div_op = op; operand_a = a; operand_b = b; req_tag = tag; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        res = rsp_result;
        tg  = rsp_tag;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (rsp_result !== 32'h0) begin n_bad++; $display("FAIL reset_result got=%h exp=0", rsp_result); end
        n_cmp++; if (rsp_tag !== 5'd0) begin n_bad++; $display("FAIL reset_tag got=%0d exp=0", rsp_tag); end
    endtask

    task automatic test_divu();
        logic [31:0] r; logic [4:0] t; int lat;
        issue(DIV_OP_DIVU, 32'd100, 32'd7, 5'd3, r, t, lat);
        n_cmp++; if (r !== 32'd14) begin n_bad++; $display("FAIL divu_100_7 got=%0d exp=14", r); end
        n_cmp++; if (t !== 5'd3) begin n_bad++; $display("FAIL divu_tag got=%0d exp=3", t); end
        n_cmp++; if (lat !== NORM_LAT) begin n_bad++; $display("FAIL divu_latency got=%0d exp=%0d", lat, NORM_LAT); end
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL divu_retire busy=%b valid=%b exp=0/0", busy, rsp_valid); end
    endtask

    task automatic test_signed();
        logic [31:0] r; logic [4:0] t; int lat;
        issue(DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, r, t, lat);
        n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rem_m7_2 got=%h exp=ffffffff", r); end
        n_cmp++; if (t !== 5'd4) begin n_bad++; $display("FAIL rem_tag got=%0d exp=4", t); end
        issue(DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, r, t, lat);
        n_cmp++; if (r !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_m7_2 got=%h exp=fffffffd", r); end
        n_cmp++; if (lat !== NORM_LAT) begin n_bad++; $display("FAIL div_latency got=%0d exp=%0d", lat, NORM_LAT); end
        issue(DIV_OP_REMU, 32'hFFFF_FFF9, 32'd2, 5'd6, r, t, lat);
        n_cmp++; if (r !== 32'd1) begin n_bad++; $display("FAIL remu_fff9_2 got=%h exp=1", r); end
        issue(DIV_OP_DIV, 32'd20, 32'hFFFF_FFFD, 5'd7, r, t, lat);
        n_cmp++; if (r !== 32'hFFFF_FFFA) begin n_bad++; $display("FAIL div_20_m3 got=%h exp=fffffffa", r); end
        issue(DIV_OP_REM, 32'd20, 32'hFFFF_FFFD, 5'd8, r, t, lat);
        n_cmp++; if (r !== 32'd2) begin n_bad++; $display("FAIL rem_20_m3 got=%h exp=2", r); end
        issue(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd16, 5'd9, r, t, lat);
        n_cmp++; if (r !== 32'h0FFF_FFFF) begin n_bad++; $display("FAIL divu_max_16 got=%h exp=0fffffff", r); end
    endtask

    task automatic test_div_zero();
        logic [31:0] r; logic [4:0] t; int lat;
        issue(DIV_OP_DIV, 32'd5, 32'd0, 5'd10, r, t, lat);
        n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_5_0 got=%h exp=ffffffff", r); end
        n_cmp++; if (lat !== SPEC_LAT) begin n_bad++; $display("FAIL div0_latency got=%0d exp=%0d", lat, SPEC_LAT); end
        n_cmp++; if (t !== 5'd10) begin n_bad++; $display("FAIL div0_tag got=%0d exp=10", t); end
        issue(DIV_OP_REM, 32'd5, 32'd0, 5'd11, r, t, lat);
        n_cmp++; if (r !== 32'd5) begin n_bad++; $display("FAIL rem_5_0 got=%h exp=5", r); end
        issue(DIV_OP_REMU, 32'hFFFF_FFF9, 32'd0, 5'd12, r, t, lat);
        n_cmp++; if (r !== 32'hFFFF_FFF9) begin n_bad++; $display("FAIL remu_x_0 got=%h exp=fffffff9", r); end
    endtask

    task automatic test_overflow();
        logic [31:0] r; logic [4:0] t; int lat;
        issue(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, r, t, lat);
        n_cmp++; if (r !== 32'h8000_0000) begin n_bad++; $display("FAIL div_ovf got=%h exp=80000000", r); end
        n_cmp++; if (lat !== SPEC_LAT) begin n_bad++; $display("FAIL ovf_latency got=%0d exp=%0d", lat, SPEC_LAT); end
        issue(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, r, t, lat);
        n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL rem_ovf got=%h exp=0", r); end
        issue(DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, r, t, lat);
        n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL divu_no_ovf got=%h exp=0", r); end
        n_cmp++; if (lat !== NORM_LAT) begin n_bad++; $display("FAIL divu_no_ovf_latency got=%0d exp=%0d", lat, NORM_LAT); end
    endtask

    task automatic test_zero_dividend();
        logic [31:0] r; logic [4:0] t; int lat;
        issue(DIV_OP_DIV, 32'd0, 32'd5, 5'd16, r, t, lat);
        n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL div_0_5 got=%h exp=0", r); end
        n_cmp++; if (lat !== SPEC_LAT) begin n_bad++; $display("FAIL zero_div_latency got=%0d exp=%0d", lat, SPEC_LAT); end
    endtask

    task automatic test_hold();
        int waited;
        @(negedge clk);
        div_op = DIV_OP_DIVU; operand_a = 32'd100; operand_b = 32'd7; req_tag = 5'd9; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        waited = 0;
        while (!rsp_valid && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL hold_timeout got=%b exp=1", rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (rsp_result !== 32'd14 || rsp_tag !== 5'd9 || req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL hold_stable cyc=%0d res=%0d tag=%0d rdy=%b vld=%b exp=14/9/0/1", i, rsp_result, rsp_tag, req_ready, rsp_valid);
            end
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        n_cmp++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release busy=%b rdy=%b vld=%b exp=0/1/0", busy, req_ready, rsp_valid); end
    endtask

    task automatic test_kill();
        logic seen;
        @(negedge clk);
        div_op = DIV_OP_DIVU; operand_a = 32'd1000; operand_b = 32'd3; req_tag = 5'd20; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL kill_busy_before got=%b exp=1", busy); end
        @(negedge clk); kill = 1'b1;
        @(posedge clk); #1; kill = 1'b0;
        n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL kill_idle rdy=%b busy=%b vld=%b exp=1/0/0", req_ready, busy, rsp_valid); end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL kill_no_rsp got=%b exp=0", seen); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        div_op = DIV_OP_DIVU; operand_a = 32'd77; operand_b = 32'd5; req_tag = 5'd21; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_ctrl rdy=%b busy=%b vld=%b exp=1/0/0", req_ready, busy, rsp_valid); end
        n_cmp++; if (rsp_result !== 32'd0 || rsp_tag !== 5'd0) begin n_bad++; $display("FAIL rstmid_data res=%h tag=%0d exp=0/0", rsp_result, rsp_tag); end
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_rsp got=%b exp=0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic [4:0] t; int lat;
        issue(DIV_OP_DIVU, 32'd1000, 32'd10, 5'd1, r, t, lat);
        n_cmp++; if (r !== 32'd100) begin n_bad++; $display("FAIL b2b_first got=%0d exp=100", r); end
        issue(DIV_OP_REMU, 32'd1003, 32'd10, 5'd2, r, t, lat);
        n_cmp++; if (r !== 32'd3 || t !== 5'd2) begin n_bad++; $display("FAIL b2b_second res=%0d tag=%0d exp=3/2", r, t); end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; div_op = DIV_OP_DIV; operand_a = 32'd0;
        operand_b = 32'd0; req_tag = 5'd0; kill = 1'b0; rsp_ready = 1'b0;
        test_reset();
        test_divu();
        test_signed();
        test_div_zero();
        test_overflow();
        test_zero_dividend();
        test_hold();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
